herring_bus_sequencer: RTL and testbench



---
 rtl/herring_bus_sequencer.sv | 122 ++++++++++++
 tb/tb_herring_bus_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/herring_bus_sequencer.sv
// 65C02 bus sequencer: derives PHI2 from clk_src, decodes chip selects and
// stretches the high phase with per-region and externally requested wait states.
module herring_bus_sequencer #(
  parameter int HALF_DIV = 5,
  parameter int ROM_WAIT = 0,
  parameter int IO_WAIT  = 10
) (
  input  logic       clk_src,
  input  logic       rst_n,
  input  logic [5:0] address,
  input  logic       rw,
  input  logic       ext_wait,
  output logic       cpu_clk_in,
  output logic [7:0] decoder,
  output logic       phi2_fall
);

  localparam logic [0:0] ST_LOW  = 1'b0;
  localparam logic [0:0] ST_HIGH = 1'b1;

  localparam logic [7:0] HALF_W  = 8'(HALF_DIV);
  localparam logic [7:0] HALF_M1 = 8'(HALF_DIV - 1);
  localparam logic [7:0] ROM_W   = 8'(ROM_WAIT);
  localparam logic [7:0] IO_W    = 8'(IO_WAIT);

  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] target_q, target_d;
  logic       rw_l_q, rw_l_d;
  logic       clk_q, clk_d;
  logic       wr_n_q, wr_n_d;
  logic [1:0] sync_q, sync_d;
  logic       ext_s;
  logic       fall;
  logic [7:0] region_w;
  logic [7:0] last_cnt;

  assign ext_s = sync_q[1];

  always_comb begin
    region_w = 8'd0;
    if (address[5:3] == 3'b111) begin
      region_w = ROM_W;
    end else if (address[5:2] == 4'b1000) begin
      region_w = IO_W;
    end
    last_cnt = target_q - 8'd1;

    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    rw_l_d   = rw_l_q;
    clk_d    = clk_q;
    wr_n_d   = 1'b1;
    fall     = 1'b0;
    sync_d   = {sync_q[0], ext_wait};

    case (state_q)
      ST_LOW: begin
        clk_d = 1'b0;
        if (cnt_q == HALF_M1) begin
          // Wait length and direction are frozen here for the whole high phase.
          state_d  = ST_HIGH;
          cnt_d    = 8'd0;
          target_d = HALF_W + region_w;
          rw_l_d   = rw;
          clk_d    = 1'b1;
          wr_n_d   = rw;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        clk_d = 1'b1;
        if (cnt_q == last_cnt) begin
          if (!ext_s) begin
            state_d = ST_LOW;
            cnt_d   = 8'd0;
            clk_d   = 1'b0;
            fall    = 1'b1;
          end
        end else begin
          // Strobe releases one cycle early so RAM sees data hold before PHI2 falls.
          cnt_d  = cnt_q + 8'd1;
          wr_n_d = rw_l_q | (cnt_d == last_cnt);
        end
      end
    endcase
  end

  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOW;
      cnt_q    <= 8'd0;
      target_q <= HALF_W;
      rw_l_q   <= 1'b1;
      clk_q    <= 1'b0;
      wr_n_q   <= 1'b1;
      sync_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      rw_l_q   <= rw_l_d;
      clk_q    <= clk_d;
      wr_n_q   <= wr_n_d;
      sync_q   <= sync_d;
    end
  end

  assign cpu_clk_in = clk_q;
  assign phi2_fall  = fall;
  assign decoder    = {1'b1,
                       ~(address == 6'b100000),
                       ~(address == 6'b100001),
                       ~(address == 6'b100010),
                       ~(address == 6'b100011),
                       1'b1,
                       ~(address[5:3] == 3'b111),
                       wr_n_q};

endmodule

// File: tb/tb_herring_bus_sequencer.sv
// Bench for herring_bus_sequencer: decode table, directed timing sequences and
// randomized traffic checked every cycle against a phase-length reference model.
module tb_herring_bus_sequencer;

  localparam int HALF_DIV = 5;
  localparam int ROM_WAIT = 2;
  localparam int IO_WAIT  = 10;

  logic       clk_src = 1'b0;
  logic       rst_n;
  logic [5:0] address;
  logic       rw;
  logic       ext_wait;
  logic       cpu_clk_in;
  logic [7:0] decoder;
  logic       phi2_fall;

  int compared   = 0;
  int mismatched = 0;
  logic check_en = 1'b0;

  herring_bus_sequencer #(
    .HALF_DIV(HALF_DIV),
    .ROM_WAIT(ROM_WAIT),
    .IO_WAIT (IO_WAIT)
  ) dut (
    .clk_src   (clk_src),
    .rst_n     (rst_n),
    .address   (address),
    .rw        (rw),
    .ext_wait  (ext_wait),
    .cpu_clk_in(cpu_clk_in),
    .decoder   (decoder),
    .phi2_fall (phi2_fall)
  );

  always #5 clk_src = ~clk_src;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int region_wait(input logic [5:0] a);
    int full;
    full = int'(a) * 1024;
    if (full >= 32'hE000) return ROM_WAIT;
    if (full >= 32'h8000 && full < 32'h9000) return IO_WAIT;
    return 0;
  endfunction

  function automatic logic [7:0] exp_decoder(input logic [5:0] a, input logic wr_n);
    int full;
    logic [7:0] d;
    full = int'(a) * 1024;
    d = 8'hFF;
    if (full >= 32'hE000) d[1] = 1'b0;
    if (full >= 32'h8000 && full < 32'h8400) d[6] = 1'b0;
    if (full >= 32'h8400 && full < 32'h8800) d[5] = 1'b0;
    if (full >= 32'h8800 && full < 32'h8C00) d[4] = 1'b0;
    if (full >= 32'h8C00 && full < 32'h9000) d[3] = 1'b0;
    d[0] = wr_n;
    return d;
  endfunction

  // Reference model: tracks cycles remaining in the current PHI2 phase.
  int   m_rem;
  logic m_high, m_wr, m_h1, m_h2;

  always @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= HALF_DIV;
      m_high <= 1'b0;
      m_wr   <= 1'b0;
      m_h1   <= 1'b0;
      m_h2   <= 1'b0;
    end else begin
      m_h1 <= ext_wait;
      m_h2 <= m_h1;
      if (!m_high) begin
        if (m_rem == 1) begin
          m_high <= 1'b1;
          m_rem  <= HALF_DIV + region_wait(address);
          m_wr   <= !rw;
        end else begin
          m_rem <= m_rem - 1;
        end
      end else if (m_rem > 1) begin
        m_rem <= m_rem - 1;
      end else if (!m_h2) begin
        m_high <= 1'b0;
        m_rem  <= HALF_DIV;
      end
    end
  end

  always @(posedge clk_src) begin
    #3;
    if (check_en) begin
      check("model_phi2", cpu_clk_in, m_high);
      check("model_decoder", decoder, exp_decoder(address, !(m_high && m_wr && m_rem > 1)));
      check("model_phi2_fall", phi2_fall, m_high && m_rem == 1 && !m_h2);
    end
  end

  // Runs one bus cycle starting at its first low sample; ends at the next one.
  task automatic run_cycle(input logic [5:0] a, input logic r,
                           input logic [5:0] mid_a, input int mid_at,
                           input int ext_at, input int ext_len,
                           output int lo, output int hi, output int falls,
                           output int wlow, output logic lastf, output logic lastw);
    address = a;
    rw      = r;
    lo = 0; hi = 0; falls = 0; wlow = 0; lastf = 1'b0; lastw = 1'b0;
    while (cpu_clk_in == 1'b0 && lo < 400) begin
      lo++;
      @(posedge clk_src); #1;
    end
    while (cpu_clk_in == 1'b1 && hi < 400) begin
      hi++;
      falls += int'(phi2_fall);
      wlow  += int'(!decoder[0]);
      lastf  = phi2_fall;
      lastw  = decoder[0];
      if (hi == mid_at) address = mid_a;
      if (hi == ext_at) ext_wait = 1'b1;
      if (ext_at > 0 && hi == ext_at + ext_len) ext_wait = 1'b0;
      @(posedge clk_src); #1;
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [6:0]  e;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lo, hi, falls, wlow, n;
    logic lastf, lastw;

    vecs[0]  = '{16'h0000, 7'b1111111};
    vecs[1]  = '{16'h0200, 7'b1111111};
    vecs[2]  = '{16'h8000, 7'b1011111};
    vecs[3]  = '{16'h8400, 7'b1101111};
    vecs[4]  = '{16'h8800, 7'b1110111};
    vecs[5]  = '{16'h8C00, 7'b1111011};
    vecs[6]  = '{16'h9000, 7'b1111111};
    vecs[7]  = '{16'hDFFF, 7'b1111111};
    vecs[8]  = '{16'hE000, 7'b1111110};
    vecs[9]  = '{16'hFFFC, 7'b1111110};
    vecs[10] = '{16'h7FFF, 7'b1111111};

    rst_n = 1'b0; address = 6'd0; rw = 1'b1; ext_wait = 1'b0;
    repeat (2) @(posedge clk_src);
    #1;
    check("rst_phi2", cpu_clk_in, 1'b0);
    check("rst_wr_n", decoder[0], 1'b1);
    check("rst_fall", phi2_fall, 1'b0);

    for (int i = 0; i < 11; i++) begin
      address = vecs[i].a[15:10];
      #1;
      check($sformatf("dec_map_%h", vecs[i].a), decoder[7:1], vecs[i].e);
    end
    address = 6'd0;

    @(negedge clk_src);
    rst_n = 1'b1;
    check_en = 1'b1;
    #1;

    // RAM read at reset release
    run_cycle(6'd0, 1'b1, 6'd0, 0, 0, 0, lo, hi, falls, wlow, lastf, lastw);
    check("ram_rd_low", lo, HALF_DIV);
    check("ram_rd_high", hi, HALF_DIV);
    check("ram_rd_falls", falls, 1);
    check("ram_rd_lastfall", lastf, 1'b1);
    check("ram_rd_wlow", wlow, 0);
    run_cycle(6'd0, 1'b1, 6'd0, 0, 0, 0, lo, hi, falls, wlow, lastf, lastw);
    check("ram_rd_period", lo + hi, 10);

    // RAM write at 0x0200
    run_cycle(6'd0, 1'b0, 6'd0, 0, 0, 0, lo, hi, falls, wlow, lastf, lastw);
    check("ram_wr_high", hi, 5);
    check("ram_wr_wlow", wlow, 4);
    check("ram_wr_last_wr_n", lastw, 1'b1);
    check("ram_wr_sel", decoder[6:1], 6'h3F);

    // I/O reads
    run_cycle(6'b100000, 1'b1, 6'd0, 0, 0, 0, lo, hi, falls, wlow, lastf, lastw);
    check("acia_high", hi, 15);
    check("acia_period", lo + hi, 20);
    check("acia_sel", decoder[6:5], 2'b01);
    run_cycle(6'b100001, 1'b1, 6'd0, 0, 0, 0, lo, hi, falls, wlow, lastf, lastw);
    check("via_high", hi, 15);
    check("via_sel", decoder[6:5], 2'b10);

    // ROM, then an address change mid-high-phase
    run_cycle(6'b111111, 1'b1, 6'd0, 0, 0, 0, lo, hi, falls, wlow, lastf, lastw);
    check("rom_high", hi, 7);
    check("rom_period", lo + hi, 12);
    check("rom_sel", decoder[1], 1'b0);
    run_cycle(6'b111111, 1'b1, 6'd0, 3, 0, 0, lo, hi, falls, wlow, lastf, lastw);
    check("rom_mid_change_high", hi, 7);

    // External stretch: asserted at high sample 2, held 20 samples
    run_cycle(6'd0, 1'b1, 6'd0, 0, 2, 20, lo, hi, falls, wlow, lastf, lastw);
    check("ext_high", hi, 2 + 20 + 2);
    check("ext_falls", falls, 1);
    check("ext_lastfall", lastf, 1'b1);
    check("ext_wlow", wlow, 0);

    // Reset pulsed in high-phase cycle 3 of a write
    address = 6'd0; rw = 1'b0; n = 0;
    while (cpu_clk_in == 1'b0 && n < 400) begin
      n++;
      @(posedge clk_src); #1;
    end
    repeat (2) @(posedge clk_src);
    #1;
    check("pre_rst_wr_n", decoder[0], 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_phi2", cpu_clk_in, 1'b0);
    check("midrst_wr_n", decoder[0], 1'b1);
    check("midrst_fall", phi2_fall, 1'b0);
    rw = 1'b1;
    @(negedge clk_src);
    rst_n = 1'b1;
    #1;
    run_cycle(6'd0, 1'b1, 6'd0, 0, 0, 0, lo, hi, falls, wlow, lastf, lastw);
    check("post_rst_low", lo, 5);
    check("post_rst_high", hi, 5);
    check("post_rst_falls", falls, 1);

    // Randomized traffic, checked each cycle by the model
    repeat (3000) begin
      @(negedge clk_src);
      if ($urandom % 4 == 0) address = 6'($urandom_range(0, 63));
      if ($urandom % 3 == 0) rw = 1'($urandom % 2);
      if (!ext_wait) ext_wait = ($urandom % 40 == 0);
      else ext_wait = ($urandom % 6 != 0);
    end
    ext_wait = 1'b0;
    repeat (40) @(posedge clk_src);
    #4;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
